ttt_multichannel_processor: RTL and testbench



---
 rtl/ttt_pkg.sv | 59 +++++
 rtl/ttt_channel_core.sv | 122 ++++++++++++
 rtl/ttt_multichannel_processor.sv | 153 +++++++++++++++
 tb/tb_ttt_multichannel_processor.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types and helpers for the multichannel tick-tock-token processor.
package ttt_pkg;

  localparam int TOKEN_W    = 8;
  localparam int DURATION_W = 8;

  typedef enum logic [3:0] {
    OP_ADD_GOOD  = 4'b0000,
    OP_ADD_BAD   = 4'b0001,
    OP_SET_GOOD  = 4'b0010,
    OP_GET_GOOD  = 4'b0011,
    OP_SET_BAD   = 4'b0100,
    OP_GET_BAD   = 4'b0101,
    OP_SET_REM   = 4'b0110,
    OP_GET_REM   = 4'b0111,
    OP_TALLY     = 4'b1000,
    OP_COUNTDOWN = 4'b1001,
    OP_SET_GTHR  = 4'b1010,
    OP_GET_GTHR  = 4'b1011,
    OP_SET_BTHR  = 4'b1100,
    OP_GET_BTHR  = 4'b1101,
    OP_SET_DUR   = 4'b1110,
    OP_GET_DUR   = 4'b1111
  } opcode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  typedef struct packed {
    logic signed [TOKEN_W-1:0] good;
    logic signed [TOKEN_W-1:0] bad;
    logic [DURATION_W-1:0]     remaining;
    logic signed [TOKEN_W-1:0] good_thr;
    logic signed [TOKEN_W-1:0] bad_thr;
    logic [DURATION_W-1:0]     duration;
  } chan_regs_t;

  // Signed add clamped to the range of a bits-wide two's complement value.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int bits);
    logic signed [32:0] sum_v;
    logic signed [32:0] hi_v;
    logic signed [32:0] lo_v;
    sum_v = 33'(a) + 33'(b);
    hi_v  = (33'sd1 <<< (bits - 32'sd1)) - 33'sd1;
    lo_v  = -(33'sd1 <<< (bits - 32'sd1));
    if (sum_v > hi_v) begin
      return 32'(hi_v);
    end else if (sum_v < lo_v) begin
      return 32'(lo_v);
    end else begin
      return 32'(sum_v);
    end
  endfunction

endpackage

// File: rtl/ttt_channel_core.sv
// Combinational next-state, read-back and event logic for one token channel.
module ttt_channel_core
  import ttt_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int TOKEN_BITS    = TOKEN_W,
  parameter int DURATION_BITS = DURATION_W
) (
  input  opcode_e                op,
  input  logic [DATA_BITS-1:0]   data_in,
  input  chan_regs_t             cur,
  output chan_regs_t             nxt,
  output logic                   start,
  output logic                   stop,
  output logic                   is_event,
  output logic [DATA_BITS-1:0]   rd_data
);

  localparam int ADD_BITS = TOKEN_BITS + 1;
  localparam logic signed [TOKEN_BITS-1:0] TOK_ZERO = {TOKEN_BITS{1'b0}};
  localparam logic [DURATION_BITS-1:0]     DUR_ZERO = {DURATION_BITS{1'b0}};
  localparam logic [DURATION_BITS-1:0]     DUR_ONE  = DURATION_BITS'(1'b1);

  logic signed [ADD_BITS-1:0]   din_ext_s;
  logic signed [TOKEN_BITS-1:0] din_tok_s;
  logic [DURATION_BITS-1:0]     din_dur_s;
  logic signed [TOKEN_BITS-1:0] good_s;
  logic signed [TOKEN_BITS-1:0] bad_s;
  logic signed [TOKEN_BITS-1:0] good_thr_s;
  logic signed [TOKEN_BITS-1:0] bad_thr_s;
  logic signed [TOKEN_BITS-1:0] good_sum_s;
  logic signed [TOKEN_BITS-1:0] bad_sum_s;
  logic                         on_s;

  assign din_ext_s  = ADD_BITS'(signed'(data_in));
  assign din_tok_s  = TOKEN_BITS'(signed'(data_in));
  assign din_dur_s  = DURATION_BITS'(data_in);
  assign good_s     = cur.good;
  assign bad_s      = cur.bad;
  assign good_thr_s = cur.good_thr;
  assign bad_thr_s  = cur.bad_thr;
  assign on_s       = (cur.remaining != DUR_ZERO);
  assign good_sum_s = TOKEN_BITS'(sat_add(32'(good_s), 32'(din_ext_s), TOKEN_BITS));
  assign bad_sum_s  = TOKEN_BITS'(sat_add(32'(bad_s), 32'(din_ext_s), TOKEN_BITS));

  // Per-opcode field update; reads echo the stored value extended to DATA_BITS.
  always_comb begin
    nxt      = cur;
    start    = 1'b0;
    stop     = 1'b0;
    is_event = 1'b0;
    rd_data  = {DATA_BITS{1'b0}};
    case (op)
      OP_ADD_GOOD: begin
        nxt.good = good_sum_s;
        rd_data  = DATA_BITS'(good_sum_s);
      end
      OP_ADD_BAD: begin
        nxt.bad = bad_sum_s;
        rd_data = DATA_BITS'(bad_sum_s);
      end
      OP_SET_GOOD: begin
        nxt.good = din_tok_s;
        rd_data  = DATA_BITS'(din_tok_s);
      end
      OP_GET_GOOD:  rd_data = DATA_BITS'(good_s);
      OP_SET_BAD: begin
        nxt.bad = din_tok_s;
        rd_data = DATA_BITS'(din_tok_s);
      end
      OP_GET_BAD:   rd_data = DATA_BITS'(bad_s);
      OP_SET_REM: begin
        nxt.remaining = din_dur_s;
        rd_data       = DATA_BITS'(din_dur_s);
      end
      OP_GET_REM:   rd_data = DATA_BITS'(cur.remaining);
      OP_TALLY: begin
        is_event = 1'b1;
        nxt.good = TOK_ZERO;
        nxt.bad  = TOK_ZERO;
        if (!on_s && (good_s >= good_thr_s) && (bad_s < bad_thr_s)) begin
          start         = 1'b1;
          stop          = (cur.duration == DUR_ZERO);
          nxt.remaining = cur.duration;
        end else if (on_s && (bad_s >= bad_thr_s)) begin
          stop          = 1'b1;
          nxt.remaining = DUR_ZERO;
        end else begin
          nxt.remaining = cur.remaining;
        end
      end
      OP_COUNTDOWN: begin
        is_event = 1'b1;
        if (on_s) begin
          nxt.remaining = cur.remaining - DUR_ONE;
          stop          = (cur.remaining == DUR_ONE);
        end else begin
          nxt.remaining = cur.remaining;
        end
      end
      OP_SET_GTHR: begin
        nxt.good_thr = din_tok_s;
        rd_data      = DATA_BITS'(din_tok_s);
      end
      OP_GET_GTHR:  rd_data = DATA_BITS'(good_thr_s);
      OP_SET_BTHR: begin
        nxt.bad_thr = din_tok_s;
        rd_data     = DATA_BITS'(din_tok_s);
      end
      OP_GET_BTHR:  rd_data = DATA_BITS'(bad_thr_s);
      OP_SET_DUR: begin
        nxt.duration = din_dur_s;
        rd_data      = DATA_BITS'(din_dur_s);
      end
      OP_GET_DUR:   rd_data = DATA_BITS'(cur.duration);
      default: begin
        nxt = cur;
      end
    endcase
  end

endmodule

// File: rtl/ttt_multichannel_processor.sv
// Multichannel token processor: per-channel register file, broadcast sweep FSM
// and registered result/event outputs around a single shared channel core.
module ttt_multichannel_processor
  import ttt_pkg::*;
#(
  parameter int NUM_CHANNELS     = 4,
  parameter int TOKEN_BITS       = TOKEN_W,
  parameter int DURATION_BITS    = DURATION_W,
  parameter int DATA_BITS        = 8,
  parameter int INSTRUCTION_BITS = 4,
  parameter int CHAN_BITS        = $clog2(NUM_CHANNELS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic [INSTRUCTION_BITS-1:0] instruction,
  input  logic [CHAN_BITS-1:0]        channel,
  input  logic                        broadcast,
  input  logic [DATA_BITS-1:0]        data_in,
  output logic [DATA_BITS-1:0]        data_out,
  output logic                        token_start,
  output logic                        token_stop,
  output logic                        token_valid,
  output logic [CHAN_BITS-1:0]        event_channel,
  output logic                        busy
);

  localparam chan_regs_t           CHAN_ZERO = chan_regs_t'({$bits(chan_regs_t){1'b0}});
  localparam logic [CHAN_BITS-1:0] CH_ZERO   = {CHAN_BITS{1'b0}};
  localparam logic [CHAN_BITS-1:0] CH_ONE    = CHAN_BITS'(1'b1);
  localparam logic [CHAN_BITS-1:0] LAST_CH   = CHAN_BITS'(NUM_CHANNELS - 1);
  localparam logic [CHAN_BITS:0]   NUM_CH_W  = (CHAN_BITS + 1)'(NUM_CHANNELS);

  sweep_state_e         state_r;
  opcode_e              sweep_op_r;
  logic [CHAN_BITS-1:0] sweep_idx_r;
  chan_regs_t           regs_r [NUM_CHANNELS];

  opcode_e              instr_op_s;
  opcode_e              act_op_s;
  logic [CHAN_BITS-1:0] act_ch_s;
  logic                 ch_ok_s;
  logic                 sweep_req_s;
  chan_regs_t           cur_s;
  chan_regs_t           nxt_s;
  logic                 start_s;
  logic                 stop_s;
  logic                 ev_s;
  logic [DATA_BITS-1:0] rd_s;

  assign instr_op_s  = opcode_e'(instruction);
  assign sweep_req_s = broadcast && ((instr_op_s == OP_TALLY) || (instr_op_s == OP_COUNTDOWN));

  // The sweep owns the core while active; otherwise the incoming instruction does.
  always_comb begin
    if (state_r == SWEEP) begin
      act_ch_s = sweep_idx_r;
      act_op_s = sweep_op_r;
    end else begin
      act_ch_s = channel;
      act_op_s = instr_op_s;
    end
    ch_ok_s = ({1'b0, act_ch_s} < NUM_CH_W);
    if (ch_ok_s) begin
      cur_s = regs_r[act_ch_s];
    end else begin
      cur_s = CHAN_ZERO;
    end
  end

  ttt_channel_core #(
    .DATA_BITS    (DATA_BITS),
    .TOKEN_BITS   (TOKEN_BITS),
    .DURATION_BITS(DURATION_BITS)
  ) u_core (
    .op      (act_op_s),
    .data_in (data_in),
    .cur     (cur_s),
    .nxt     (nxt_s),
    .start   (start_s),
    .stop    (stop_s),
    .is_event(ev_s),
    .rd_data (rd_s)
  );

  // Channel registers, sweep FSM and registered outputs; ena low freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        regs_r[i] <= CHAN_ZERO;
      end
      state_r       <= IDLE;
      sweep_op_r    <= OP_TALLY;
      sweep_idx_r   <= CH_ZERO;
      data_out      <= {DATA_BITS{1'b0}};
      token_start   <= 1'b0;
      token_stop    <= 1'b0;
      token_valid   <= 1'b0;
      event_channel <= CH_ZERO;
      busy          <= 1'b0;
    end else if (ena) begin
      case (state_r)
        IDLE: begin
          if (sweep_req_s) begin
            state_r     <= SWEEP;
            sweep_op_r  <= instr_op_s;
            sweep_idx_r <= CH_ZERO;
            busy        <= 1'b1;
            token_valid <= 1'b0;
          end else if (!ch_ok_s) begin
            data_out    <= {DATA_BITS{1'b0}};
            token_valid <= 1'b0;
            token_start <= 1'b0;
            token_stop  <= 1'b0;
          end else begin
            regs_r[act_ch_s] <= nxt_s;
            if (ev_s) begin
              token_valid   <= 1'b1;
              token_start   <= start_s;
              token_stop    <= stop_s;
              event_channel <= act_ch_s;
            end else begin
              data_out    <= rd_s;
              token_valid <= 1'b0;
              token_start <= 1'b0;
              token_stop  <= 1'b0;
            end
          end
        end
        SWEEP: begin
          regs_r[act_ch_s] <= nxt_s;
          token_valid      <= 1'b1;
          token_start      <= start_s;
          token_stop       <= stop_s;
          event_channel    <= act_ch_s;
          if (sweep_idx_r == LAST_CH) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            sweep_idx_r <= sweep_idx_r + CH_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end else begin
      token_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ttt_multichannel_processor.sv
// Directed self-checking bench for ttt_multichannel_processor (4 channels, 8-bit fields).
module tb_ttt_multichannel_processor;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] instruction;
  logic [1:0] channel;
  logic       broadcast;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       token_start;
  logic       token_stop;
  logic       token_valid;
  logic [1:0] event_channel;
  logic       busy;

  int n_cmp;
  int n_bad;

  ttt_multichannel_processor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .instruction  (instruction),
    .channel      (channel),
    .broadcast    (broadcast),
    .data_in      (data_in),
    .data_out     (data_out),
    .token_start  (token_start),
    .token_stop   (token_stop),
    .token_valid  (token_valid),
    .event_channel(event_channel),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive(input logic [3:0] op, input logic [1:0] ch, input logic [7:0] d, input logic bc);
    instruction = op;
    channel     = ch;
    data_in     = d;
    broadcast   = bc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [1:0] ch, input logic [7:0] d);
    ena = 1'b1;
    drive(op, ch, d, 1'b0);
    step();
  endtask

  task automatic test_reset();
    logic [3:0] gets [6];
    gets = '{4'b0011, 4'b0101, 4'b0111, 4'b1011, 4'b1101, 4'b1111};
    rst_n = 1'b0;
    ena   = 1'b0;
    drive(4'b0000, 2'd0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({data_out, token_start, token_stop, token_valid, event_channel, busy} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got dout=%h st=%b sp=%b tv=%b ec=%0d busy=%b, want all 0",
               data_out, token_start, token_stop, token_valid, event_channel, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      for (int g = 0; g < 6; g++) begin
        do_op(gets[g], 2'(c), 8'hA5);
        n_cmp++;
        if (data_out !== 8'h00 || token_valid !== 1'b0 || busy !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_read ch%0d op%b: got dout=%h tv=%b busy=%b, want 00/0/0",
                   c, gets[g], data_out, token_valid, busy);
        end
      end
    end
  endtask

  task automatic test_tally_countdown();
    do_op(4'b1010, 2'd1, 8'd3);
    n_cmp++;
    if (data_out !== 8'd3) begin n_bad++; $display("FAIL set_gthr: got %h want 03", data_out); end
    do_op(4'b1100, 2'd1, 8'd2);
    do_op(4'b1110, 2'd1, 8'd2);
    n_cmp++;
    if (data_out !== 8'd2) begin n_bad++; $display("FAIL set_dur: got %h want 02", data_out); end
    do_op(4'b0000, 2'd1, 8'd3);
    n_cmp++;
    if (data_out !== 8'd3) begin n_bad++; $display("FAIL add_good: got %h want 03", data_out); end
    do_op(4'b1000, 2'd1, 8'hEE);
    n_cmp++;
    if ({token_valid, token_start, token_stop, event_channel, data_out} !== {3'b110, 2'd1, 8'd3}) begin
      n_bad++;
      $display("FAIL tally_start: got tv=%b st=%b sp=%b ec=%0d dout=%h want 1/1/0/1/03",
               token_valid, token_start, token_stop, event_channel, data_out);
    end
    do_op(4'b0111, 2'd1, 8'h00);
    n_cmp++;
    if (data_out !== 8'd2 || token_valid !== 1'b0) begin
      n_bad++; $display("FAIL rem_after_tally: got %h tv=%b want 02 tv=0", data_out, token_valid);
    end
    do_op(4'b0011, 2'd1, 8'h00);
    n_cmp++;
    if (data_out !== 8'd0) begin n_bad++; $display("FAIL good_cleared: got %h want 00", data_out); end
    do_op(4'b1001, 2'd1, 8'h00);
    n_cmp++;
    if ({token_valid, token_start, token_stop} !== 3'b100) begin
      n_bad++; $display("FAIL countdown1: got tv/st/sp=%b%b%b want 100", token_valid, token_start, token_stop);
    end
    do_op(4'b1001, 2'd1, 8'h00);
    n_cmp++;
    if ({token_valid, token_start, token_stop, event_channel} !== {3'b101, 2'd1}) begin
      n_bad++; $display("FAIL countdown2: got tv/st/sp=%b%b%b ec=%0d want 101 ec=1",
                        token_valid, token_start, token_stop, event_channel);
    end
    do_op(4'b1001, 2'd1, 8'h00);
    n_cmp++;
    if ({token_valid, token_stop} !== 2'b10) begin
      n_bad++; $display("FAIL countdown_idle: got tv=%b sp=%b want 1/0", token_valid, token_stop);
    end
    do_op(4'b0111, 2'd1, 8'h00);
    n_cmp++;
    if (data_out !== 8'd0) begin n_bad++; $display("FAIL rem_zero: got %h want 00", data_out); end
  endtask

  task automatic test_saturation();
    logic [3:0] ops  [5];
    logic [7:0] dins [5];
    logic [7:0] exps [5];
    ops  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    dins = '{8'd120,  8'd20,   8'h80,   8'h80,   8'hFB};
    exps = '{8'h78,   8'h7F,   8'hFF,   8'h80,   8'hFB};
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], 2'd2, dins[i]);
      n_cmp++;
      if (data_out !== exps[i]) begin
        n_bad++; $display("FAIL sat_step%0d: got %h want %h", i, data_out, exps[i]);
      end
    end
    do_op(4'b0011, 2'd2, 8'h00);
    n_cmp++;
    if (data_out !== 8'h80) begin n_bad++; $display("FAIL sat_readback: got %h want 80", data_out); end
  endtask

  task automatic test_broadcast();
    do_op(4'b1100, 2'd0, 8'd1);
    do_op(4'b1110, 2'd0, 8'd5);
    do_op(4'b1100, 2'd3, 8'd1);
    do_op(4'b1110, 2'd3, 8'd0);
    do_op(4'b1111, 2'd0, 8'h00);
    drive(4'b1000, 2'd2, 8'h00, 1'b1);
    step();
    n_cmp++;
    if (busy !== 1'b1 || token_valid !== 1'b0 || data_out !== 8'd5) begin
      n_bad++; $display("FAIL bc_accept: got busy=%b tv=%b dout=%h want 1/0/05", busy, token_valid, data_out);
    end
    drive(4'b1110, 2'd1, 8'd9, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (token_valid !== 1'b1 || event_channel !== 2'(k) || token_start !== (k == 0 || k == 3) ||
          token_stop !== (k == 3) || busy !== (k < 3) || data_out !== 8'd5) begin
        n_bad++;
        $display("FAIL bc_sweep%0d: got tv=%b ec=%0d st=%b sp=%b busy=%b dout=%h", k,
                 token_valid, event_channel, token_start, token_stop, busy, data_out);
      end
    end
    do_op(4'b1111, 2'd1, 8'h00);
    n_cmp++;
    if (data_out !== 8'd2 || busy !== 1'b0 || token_valid !== 1'b0) begin
      n_bad++; $display("FAIL bc_ignored_instr: got dout=%h busy=%b tv=%b want 02/0/0", data_out, busy, token_valid);
    end
    do_op(4'b0111, 2'd0, 8'h00);
    n_cmp++;
    if (data_out !== 8'd5) begin n_bad++; $display("FAIL bc_rem_ch0: got %h want 05", data_out); end
    do_op(4'b0111, 2'd3, 8'h00);
    n_cmp++;
    if (data_out !== 8'd0) begin n_bad++; $display("FAIL bc_rem_ch3: got %h want 00", data_out); end
  endtask

  task automatic test_ena_pause();
    drive(4'b1001, 2'd0, 8'h00, 1'b1);
    ena = 1'b1;
    step();
    step();
    n_cmp++;
    if (token_valid !== 1'b1 || event_channel !== 2'd0 || token_stop !== 1'b0) begin
      n_bad++; $display("FAIL pause_first: got tv=%b ec=%0d sp=%b want 1/0/0", token_valid, event_channel, token_stop);
    end
    ena = 1'b0;
    for (int p = 0; p < 2; p++) begin
      step();
      n_cmp++;
      if (token_valid !== 1'b0 || busy !== 1'b1 || event_channel !== 2'd0) begin
        n_bad++; $display("FAIL pause_hold%0d: got tv=%b busy=%b ec=%0d want 0/1/0", p, token_valid, busy, event_channel);
      end
    end
    ena = 1'b1;
    drive(4'b0011, 2'd0, 8'h00, 1'b0);
    for (int k = 1; k < 4; k++) begin
      step();
      n_cmp++;
      if (token_valid !== 1'b1 || event_channel !== 2'(k) || token_stop !== 1'b0 || busy !== (k < 3)) begin
        n_bad++; $display("FAIL pause_resume%0d: got tv=%b ec=%0d sp=%b busy=%b", k,
                          token_valid, event_channel, token_stop, busy);
      end
    end
    do_op(4'b0111, 2'd0, 8'h00);
    n_cmp++;
    if (data_out !== 8'd4) begin n_bad++; $display("FAIL pause_rem_ch0: got %h want 04", data_out); end
  endtask

  task automatic test_tally_stop();
    do_op(4'b0001, 2'd0, 8'd1);
    do_op(4'b1000, 2'd0, 8'h00);
    n_cmp++;
    if ({token_valid, token_start, token_stop, event_channel, data_out} !== {3'b101, 2'd0, 8'd1}) begin
      n_bad++; $display("FAIL tally_stop: got tv=%b st=%b sp=%b ec=%0d dout=%h want 1/0/1/0/01",
                        token_valid, token_start, token_stop, event_channel, data_out);
    end
    do_op(4'b0111, 2'd0, 8'h00);
    n_cmp++;
    if (data_out !== 8'd0) begin n_bad++; $display("FAIL tally_stop_rem: got %h want 00", data_out); end
  endtask

  task automatic test_reset_midsweep();
    do_op(4'b0010, 2'd3, 8'h11);
    drive(4'b1000, 2'd0, 8'h00, 1'b1);
    step();
    step();
    n_cmp++;
    if (token_start !== 1'b1 || data_out !== 8'h11) begin
      n_bad++; $display("FAIL rst_pre: got st=%b dout=%h want 1/11", token_start, data_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({data_out, token_start, token_stop, token_valid, event_channel, busy} !== 13'd0) begin
      n_bad++; $display("FAIL rst_async: got dout=%h st=%b sp=%b tv=%b ec=%0d busy=%b want all 0",
                        data_out, token_start, token_stop, token_valid, event_channel, busy);
    end
    drive(4'b0011, 2'd3, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'b0011, 2'd3, 8'h00);
    n_cmp++;
    if (data_out !== 8'd0 || busy !== 1'b0 || token_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_good_ch3: got dout=%h busy=%b tv=%b want 00/0/0", data_out, busy, token_valid);
    end
    do_op(4'b1101, 2'd0, 8'h00);
    n_cmp++;
    if (data_out !== 8'd0) begin n_bad++; $display("FAIL rst_bthr_ch0: got %h want 00", data_out); end
    do_op(4'b1111, 2'd1, 8'h00);
    n_cmp++;
    if (data_out !== 8'd0) begin n_bad++; $display("FAIL rst_dur_ch1: got %h want 00", data_out); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_tally_countdown();
    test_saturation();
    test_broadcast();
    test_ena_pause();
    test_tally_stop();
    test_reset_midsweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
